led_sweep_event: RTL

LED_SWEEP_EVENT -- requirements
Module: led_sweep_event

---
 rtl/led_sweep_pkg.sv | 36 +++
 rtl/led_sweep_event_if.sv | 28 ++
 rtl/step_prescaler.sv | 31 +++
 rtl/led_sweep_event.sv | 116 +++++++++++
 4 files changed

// File: rtl/led_sweep_pkg.sv
// Shared types for the LED sweep block: FSM states, sweep-mode encoding and
// the lamp-pattern helper used by the led decode.
package led_sweep_pkg;

    localparam int MAX_LEDS = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        MODE_DOT_UP   = 2'b00,
        MODE_DOT_DOWN = 2'b01,
        MODE_BAR_UP   = 2'b10,
        MODE_BAR_DOWN = 2'b11
    } sweep_mode_e;

    // Lamp pattern for position p of an n-lamp strip; bits at or above n stay 0.
    function automatic logic [MAX_LEDS-1:0] sweep_pattern(sweep_mode_e m, int p, int n);
        logic [MAX_LEDS-1:0] pat;
        pat = '0;
        for (int i = 0; i < MAX_LEDS; i++) begin
            case (m)
                MODE_DOT_UP:   pat[i] = (i == p);
                MODE_DOT_DOWN: pat[i] = (i == n - 1 - p);
                MODE_BAR_UP:   pat[i] = (i <= p);
                MODE_BAR_DOWN: pat[i] = (i >= n - 1 - p) && (i < n);
                default:       pat[i] = 1'b0;
            endcase
        end
        return pat;
    endfunction

endpackage

// File: rtl/led_sweep_event_if.sv
// Button/mode request and lamp/status response bundle of the LED sweep block.
interface led_sweep_event_if #(
    parameter int NUM_LEDS = 8
) ();

    logic                button_inp;
    logic [1:0]          mode;
    logic [NUM_LEDS-1:0] led;
    logic                busy;
    logic                done;

    modport master (
        output button_inp,
        output mode,
        input  led,
        input  busy,
        input  done
    );

    modport slave (
        input  button_inp,
        input  mode,
        output led,
        output busy,
        output done
    );

endinterface

// File: rtl/step_prescaler.sv
// Divides the clock by STEP_DIV while enabled; tick marks the last cycle of
// each step. The count is held at zero whenever en is low.
module step_prescaler #(
    parameter int STEP_DIV = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam int                CNT_W    = $clog2(STEP_DIV + 1);
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(STEP_DIV - 1);

    logic [CNT_W-1:0] cnt;

    assign tick = en && (cnt == LAST_CNT);

    // NOTE: sequential state is always assigned with <= so every register
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt <= '0;
        end else if (!en || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/led_sweep_event.sv
// LED sweep controller: a button press runs one lamp sweep in the latched mode.
// Define LED_SWEEP_LOOP_EN to make the sweep repeat while the button is held.
module led_sweep_event
    import led_sweep_pkg::*;
#(
    parameter int NUM_LEDS = 8,
    parameter int STEP_DIV = 1
) (
    input  logic               clk,
    input  logic               rst,
    led_sweep_event_if.slave   bus
);

    localparam int               POS_W    = $clog2(NUM_LEDS);
    localparam logic [POS_W-1:0] LAST_POS = POS_W'(NUM_LEDS - 1);

`ifdef LED_SWEEP_LOOP_EN
    localparam bit LOOP_EN = 1'b1;
`else
    localparam bit LOOP_EN = 1'b0;
`endif

    state_e              state, state_d;
    sweep_mode_e         mode_q, mode_d;
    logic [POS_W-1:0]    pos, pos_d;
    logic [NUM_LEDS-1:0] led_q, led_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [MAX_LEDS-1:0] pattern;
    logic                run_en;
    logic                tick;
    logic                last_step;

    assign run_en    = (state == RUN);
    assign last_step = tick && (pos == LAST_POS);

    step_prescaler #(
        .STEP_DIV (STEP_DIV)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .en   (run_en),
        .tick (tick)
    );

    // State register, together with the registered datapath and outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= IDLE;
            mode_q <= MODE_DOT_UP;
            pos    <= '0;
            led_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state  <= state_d;
            mode_q <= mode_d;
            pos    <= pos_d;
            led_q  <= led_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    // Next state. A release in RUN aborts even on the final step.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        state_d = state;
        case (state)
            IDLE: if (bus.button_inp) state_d = RUN;
            RUN: begin
                if (!bus.button_inp)           state_d = IDLE;
                else if (last_step && !LOOP_EN) state_d = DONE;
            end
            DONE: if (!bus.button_inp) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Next register values; led is decoded from the position and mode that
    // take effect on this edge, so the first lamp lights on entry to RUN.
    always_comb begin
        mode_d = mode_q;
        pos_d  = pos;
        done_d = 1'b0;
        case (state)
            IDLE: begin
                if (bus.button_inp) begin
                    mode_d = sweep_mode_e'(bus.mode);
                    pos_d  = '0;
                end
            end
            RUN: begin
                if (!bus.button_inp) begin
                    pos_d = '0;
                end else if (last_step) begin
                    pos_d  = '0;
                    done_d = 1'b1;
                end else if (tick) begin
                    pos_d = pos + 1'b1;
                end
            end
            default: pos_d = '0;
        endcase

        pattern = sweep_pattern(mode_d, int'(pos_d), NUM_LEDS);
        led_d   = (state_d == RUN) ? pattern[NUM_LEDS-1:0] : '0;
        busy_d  = (state_d == RUN);
    end

    assign bus.led  = led_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;

endmodule
